// File: rtl/hazard3_sba_ctrl.sv
// rtl/hazard3_sba_ctrl.sv - Debug Module System Bus Access sequencer
//
// Turns sbaddress0/sbdata0 register traffic from the Debug Module into single
// transfers on the core's dbg_sbus_* port, tracking sbbusy, sbbusyerror and
// sberror. Misaligned or oversized requests are rejected before issue.
//
// Configuration macro: HAZARD3_SBA_AUTOINCREMENT_EN
//   defined   : cfg_autoinc advances sbaddr by the transfer size after each
//               successful transfer.
//   undefined : cfg_autoinc is ignored; sbaddr only changes on DM writes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_*               sbcs configuration fields (readonaddr, readondata,
//                       autoincrement, access size)
//   sbaddr_wen/wdata    DM write of sbaddress0
//   sbdata_wen/wdata    DM write of sbdata0
//   sbdata_ren          DM read strobe of sbdata0
//   sberror_clr         W1C mask for sberror
//   sbbusyerror_clr     W1C for sbbusyerror
//   sbaddr, sbdata      current register values
//   sbbusy              transfer in flight
//   sbbusyerror         sticky busy-violation flag
//   sberror             sticky error code (2 bus, 3 misaligned, 4 bad size)
//   dbg_sbus_*          single-transfer request/response port to the core

module hazard3_sba_ctrl #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_readonaddr,
    input  logic              cfg_readondata,
    input  logic              cfg_autoinc,
    input  logic [2:0]        cfg_access,
    input  logic              sbaddr_wen,
    input  logic [W_ADDR-1:0] sbaddr_wdata,
    input  logic              sbdata_wen,
    input  logic [W_DATA-1:0] sbdata_wdata,
    input  logic              sbdata_ren,
    input  logic [2:0]        sberror_clr,
    input  logic              sbbusyerror_clr,
    output logic [W_ADDR-1:0] sbaddr,
    output logic [W_DATA-1:0] sbdata,
    output logic              sbbusy,
    output logic              sbbusyerror,
    output logic [2:0]        sberror,
    output logic [W_ADDR-1:0] dbg_sbus_addr,
    output logic              dbg_sbus_write,
    output logic [1:0]        dbg_sbus_size,
    output logic [W_DATA-1:0] dbg_sbus_wdata,
    output logic              dbg_sbus_vld,
    input  logic              dbg_sbus_rdy,
    input  logic              dbg_sbus_err,
    input  logic [W_DATA-1:0] dbg_sbus_rdata
);

`ifdef HAZARD3_SBA_AUTOINCREMENT_EN
    localparam bit AUTOINC_SUPPORTED = 1'b1;
`else
    localparam bit AUTOINC_SUPPORTED = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t state;

    localparam logic [W_ADDR-1:0] ADDR_ONE = {{(W_ADDR-1){1'b0}}, 1'b1};

    logic              strobe_any;
    logic              trig_req;
    logic              trig_write;
    logic [W_ADDR-1:0] trig_addr;
    logic              trig_ok;
    logic              bad_size;
    logic              misaligned;
    logic              issue;
    logic              err_set;
    logic [2:0]        err_val;
    logic              busyerr_set;
    logic              done;
    logic              autoinc_en;

    // Trigger decode: only the highest-priority strobe in a cycle has any effect.
    always_comb begin
        strobe_any = sbaddr_wen | sbdata_wen | sbdata_ren;
        trig_req   = 1'b0;
        trig_write = 1'b0;
        trig_addr  = sbaddr;
        if (sbaddr_wen) begin
            trig_addr = sbaddr_wdata;
            trig_req  = cfg_readonaddr;
        end else if (sbdata_wen) begin
            trig_req   = 1'b1;
            trig_write = 1'b1;
        end else if (sbdata_ren) begin
            trig_req = cfg_readondata;
        end

        trig_ok  = (state == ST_IDLE) && trig_req && !sbbusyerror && (sberror == 3'd0);
        bad_size = (cfg_access > 3'd2);
        case (cfg_access)
            3'd1:    misaligned = trig_addr[0];
            3'd2:    misaligned = |trig_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        issue = trig_ok && !bad_size && !misaligned;

        done = (state == ST_BUSY) && dbg_sbus_rdy;

        err_set = 1'b0;
        err_val = 3'd0;
        if (trig_ok && bad_size) begin
            err_set = 1'b1;
            err_val = 3'd4;
        end else if (trig_ok && misaligned) begin
            err_set = 1'b1;
            err_val = 3'd3;
        end else if (done && dbg_sbus_err) begin
            err_set = 1'b1;
            err_val = 3'd2;
        end

        busyerr_set = (state == ST_BUSY) && strobe_any;
        autoinc_en  = AUTOINC_SUPPORTED && cfg_autoinc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sbaddr         <= '0;
            sbdata         <= '0;
            sbbusyerror    <= 1'b0;
            sberror        <= 3'd0;
            dbg_sbus_addr  <= '0;
            dbg_sbus_write <= 1'b0;
            dbg_sbus_size  <= 2'd0;
            dbg_sbus_wdata <= '0;
        end else begin
            // A new set in the same cycle as a W1C clear takes precedence.
            sbbusyerror <= busyerr_set | (sbbusyerror & ~sbbusyerror_clr);
            sberror     <= err_set ? err_val : (sberror & ~sberror_clr);

            case (state)
                ST_IDLE: begin
                    // Register writes land even when an error blocks the transfer.
                    if (sbaddr_wen) begin
                        sbaddr <= sbaddr_wdata;
                    end else if (sbdata_wen) begin
                        sbdata <= sbdata_wdata;
                    end
                    if (issue) begin
                        state          <= ST_BUSY;
                        dbg_sbus_addr  <= trig_addr;
                        dbg_sbus_write <= trig_write;
                        dbg_sbus_size  <= cfg_access[1:0];
                        dbg_sbus_wdata <= sbdata_wdata;
                    end
                end
                ST_BUSY: begin
                    // Request fields stay frozen until the bus accepts them.
                    if (dbg_sbus_rdy) begin
                        state <= ST_IDLE;
                        if (!dbg_sbus_err) begin
                            if (!dbg_sbus_write) begin
                                sbdata <= dbg_sbus_rdata;
                            end
                            if (autoinc_en) begin
                                sbaddr <= sbaddr + (ADDR_ONE << dbg_sbus_size);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sbbusy = (state == ST_BUSY);
    // The bus is reset alongside us, so the request is withdrawn during reset.
    assign dbg_sbus_vld = sbbusy && !rst;

endmodule

// File: tb/tb_hazard3_sba_ctrl.sv
// tb/tb_hazard3_sba_ctrl.sv - directed self-checking bench for hazard3_sba_ctrl

module tb_hazard3_sba_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_readonaddr;
    logic        cfg_readondata;
    logic        cfg_autoinc;
    logic [2:0]  cfg_access;
    logic        sbaddr_wen;
    logic [31:0] sbaddr_wdata;
    logic        sbdata_wen;
    logic [31:0] sbdata_wdata;
    logic        sbdata_ren;
    logic [2:0]  sberror_clr;
    logic        sbbusyerror_clr;
    logic [31:0] sbaddr;
    logic [31:0] sbdata;
    logic        sbbusy;
    logic        sbbusyerror;
    logic [2:0]  sberror;
    logic [31:0] dbg_sbus_addr;
    logic        dbg_sbus_write;
    logic [1:0]  dbg_sbus_size;
    logic [31:0] dbg_sbus_wdata;
    logic        dbg_sbus_vld;
    logic        dbg_sbus_rdy;
    logic        dbg_sbus_err;
    logic [31:0] dbg_sbus_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard3_sba_ctrl #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_readonaddr  (cfg_readonaddr),
        .cfg_readondata  (cfg_readondata),
        .cfg_autoinc     (cfg_autoinc),
        .cfg_access      (cfg_access),
        .sbaddr_wen      (sbaddr_wen),
        .sbaddr_wdata    (sbaddr_wdata),
        .sbdata_wen      (sbdata_wen),
        .sbdata_wdata    (sbdata_wdata),
        .sbdata_ren      (sbdata_ren),
        .sberror_clr     (sberror_clr),
        .sbbusyerror_clr (sbbusyerror_clr),
        .sbaddr          (sbaddr),
        .sbdata          (sbdata),
        .sbbusy          (sbbusy),
        .sbbusyerror     (sbbusyerror),
        .sberror         (sberror),
        .dbg_sbus_addr   (dbg_sbus_addr),
        .dbg_sbus_write  (dbg_sbus_write),
        .dbg_sbus_size   (dbg_sbus_size),
        .dbg_sbus_wdata  (dbg_sbus_wdata),
        .dbg_sbus_vld    (dbg_sbus_vld),
        .dbg_sbus_rdy    (dbg_sbus_rdy),
        .dbg_sbus_err    (dbg_sbus_err),
        .dbg_sbus_rdata  (dbg_sbus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        autoinc_built;
`ifdef HAZARD3_SBA_AUTOINCREMENT_EN
        autoinc_built = 1'b1;
`else
        autoinc_built = 1'b0;
`endif
        rst = 1'b1;
        cfg_readonaddr = 1'b0; cfg_readondata = 1'b0; cfg_autoinc = 1'b0; cfg_access = 3'd2;
        sbaddr_wen = 1'b0; sbaddr_wdata = 32'h0; sbdata_wen = 1'b0; sbdata_wdata = 32'h0;
        sbdata_ren = 1'b0; sberror_clr = 3'd0; sbbusyerror_clr = 1'b0;
        dbg_sbus_rdy = 1'b0; dbg_sbus_err = 1'b0; dbg_sbus_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_sbaddr", sbaddr, 32'h0);
        chk("rst_sbdata", sbdata, 32'h0);
        chk("rst_busy", sbbusy, 1'b0);
        chk("rst_vld", dbg_sbus_vld, 1'b0);
        chk("rst_sberror", sberror, 3'd0);
        chk("rst_busyerr", sbbusyerror, 1'b0);

        cfg_readonaddr = 1'b1; cfg_access = 3'd2;
        sbaddr_wen = 1'b1; sbaddr_wdata = 32'h1000;
        tick();
        sbaddr_wen = 1'b0;
        chk("rd_vld", dbg_sbus_vld, 1'b1);
        chk("rd_addr", dbg_sbus_addr, 32'h1000);
        chk("rd_write", dbg_sbus_write, 1'b0);
        chk("rd_size", dbg_sbus_size, 2'd2);
        dbg_sbus_rdy = 1'b1; dbg_sbus_rdata = 32'hCAFEF00D;
        tick();
        dbg_sbus_rdy = 1'b0;
        chk("rd_sbdata", sbdata, 32'hCAFEF00D);
        chk("rd_busy_low", sbbusy, 1'b0);
        chk("rd_sbaddr", sbaddr, 32'h1000);

        cfg_readonaddr = 1'b0; cfg_access = 3'd1; cfg_autoinc = 1'b1;
        sbaddr_wen = 1'b1; sbaddr_wdata = 32'h2;
        tick();
        sbaddr_wen = 1'b0;
        chk("ai_no_trig", sbbusy, 1'b0);
        exp_addr = 32'h2;
        for (int i = 1; i <= 3; i++) begin
            sbdata_wen = 1'b1; sbdata_wdata = 32'h1111 * i;
            tick();
            sbdata_wen = 1'b0;
            chk("ai_vld", dbg_sbus_vld, 1'b1);
            chk("ai_addr", dbg_sbus_addr, exp_addr);
            chk("ai_write", dbg_sbus_write, 1'b1);
            chk("ai_size", dbg_sbus_size, 2'd1);
            chk("ai_wdata", dbg_sbus_wdata, 32'h1111 * i);
            dbg_sbus_rdy = 1'b1;
            tick();
            dbg_sbus_rdy = 1'b0;
            chk("ai_done", sbbusy, 1'b0);
            if (autoinc_built) exp_addr = exp_addr + 32'h2;
        end
        chk("ai_final_addr", sbaddr, exp_addr);
        chk("ai_sbdata", sbdata, 32'h3333);
        cfg_autoinc = 1'b0;

        sbdata_wen = 1'b1; sbdata_wdata = 32'hAAAA;
        tick();
        sbdata_wdata = 32'h5555;
        tick();
        sbdata_wen = 1'b0;
        chk("bv_busyerr", sbbusyerror, 1'b1);
        chk("bv_wdata_held", dbg_sbus_wdata, 32'hAAAA);
        chk("bv_addr_held", dbg_sbus_addr, exp_addr);
        tick(); tick(); tick();
        chk("bv_vld_held", dbg_sbus_vld, 1'b1);
        chk("bv_sbdata", sbdata, 32'hAAAA);
        dbg_sbus_rdy = 1'b1;
        tick();
        dbg_sbus_rdy = 1'b0;
        chk("bv_done", sbbusy, 1'b0);
        sbdata_wen = 1'b1; sbdata_wdata = 32'h7777;
        tick();
        sbdata_wen = 1'b0;
        chk("bv_blocked", dbg_sbus_vld, 1'b0);
        chk("bv_side_effect", sbdata, 32'h7777);
        sbbusyerror_clr = 1'b1;
        tick();
        sbbusyerror_clr = 1'b0;
        chk("bv_cleared", sbbusyerror, 1'b0);

        cfg_readonaddr = 1'b1; cfg_access = 3'd2;
        sbaddr_wen = 1'b1; sbaddr_wdata = 32'h3;
        tick();
        sbaddr_wen = 1'b0;
        chk("mis_err", sberror, 3'd3);
        chk("mis_vld", dbg_sbus_vld, 1'b0);
        chk("mis_sbaddr", sbaddr, 32'h3);
        tick();
        chk("mis_vld_later", dbg_sbus_vld, 1'b0);
        sberror_clr = 3'd7;
        tick();
        sberror_clr = 3'd0;
        chk("mis_cleared", sberror, 3'd0);
        cfg_access = 3'd3;
        sbaddr_wen = 1'b1; sbaddr_wdata = 32'h10;
        tick();
        sbaddr_wen = 1'b0;
        chk("size_err", sberror, 3'd4);
        chk("size_vld", dbg_sbus_vld, 1'b0);
        sberror_clr = 3'd7;
        tick();
        sberror_clr = 3'd0;

        cfg_access = 3'd2; cfg_autoinc = 1'b1;
        sbaddr_wen = 1'b1; sbaddr_wdata = 32'h20;
        tick();
        sbaddr_wen = 1'b0;
        chk("be_vld", dbg_sbus_vld, 1'b1);
        dbg_sbus_rdy = 1'b1; dbg_sbus_err = 1'b1; dbg_sbus_rdata = 32'h12345678;
        tick();
        dbg_sbus_rdy = 1'b0; dbg_sbus_err = 1'b0;
        chk("be_err", sberror, 3'd2);
        chk("be_sbdata", sbdata, 32'h7777);
        chk("be_sbaddr", sbaddr, 32'h20);
        chk("be_busy", sbbusy, 1'b0);
        sberror_clr = 3'd2;
        tick();
        sberror_clr = 3'd0;
        cfg_autoinc = 1'b0;

        cfg_readonaddr = 1'b0; cfg_readondata = 1'b1;
        sbdata_ren = 1'b1;
        tick();
        sbdata_ren = 1'b0;
        chk("rod_vld", dbg_sbus_vld, 1'b1);
        chk("rod_addr", dbg_sbus_addr, 32'h20);
        dbg_sbus_rdy = 1'b1; dbg_sbus_rdata = 32'hDEADBEEF;
        tick();
        dbg_sbus_rdy = 1'b0;
        chk("rod_sbdata", sbdata, 32'hDEADBEEF);

        sbdata_ren = 1'b1;
        tick();
        sbdata_ren = 1'b0;
        chk("rb_busy", sbbusy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rb_vld_in_rst", dbg_sbus_vld, 1'b0);
        tick();
        rst = 1'b0;
        chk("rb_vld", dbg_sbus_vld, 1'b0);
        chk("rb_busy_low", sbbusy, 1'b0);
        chk("rb_sbaddr", sbaddr, 32'h0);
        chk("rb_sbdata", sbdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
